// File: rtl/uart_tx_scheduler.sv
// rtl/uart_tx_scheduler.sv - round-robin sharing of one byte-serial UART transmitter between N requesters
module uart_tx_scheduler #(
    parameter int N           = 4,
    parameter int TIMEOUT_CYC = 2000000,
    parameter int TW          = 21
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req_valid,
    input  logic [8*N-1:0]       req_data,
    input  logic [N-1:0]         req_last,
    output logic [N-1:0]         req_ack,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    input  logic                 tx_ready,
    output logic [$clog2(N)-1:0] owner,
    output logic                 locked,
    output logic                 busy,
    output logic                 err_timeout
);
    localparam int OW = $clog2(N);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]    state_q, state_d;
    logic          tx_start_q, tx_start_d;
    logic [7:0]    tx_data_q, tx_data_d;
    logic [N-1:0]  req_ack_q, req_ack_d;
    logic [OW-1:0] owner_q, owner_d;
    logic          locked_q, locked_d;
    logic          err_q, err_d;
    logic [OW-1:0] rr_q, rr_d;
    logic          ready_q, ready_d;
    logic [TW-1:0] cnt_q, cnt_d;

    logic          rise, fall, timeout, found;
    logic [OW-1:0] win, next_owner;

    function automatic logic [OW-1:0] wrap_inc(input logic [OW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= N) s = s - N;
        return OW'(s);
    endfunction

    assign ready_d    = tx_ready;
    assign rise       = tx_ready & ~ready_q;
    assign fall       = ~tx_ready & ready_q;
    assign timeout    = (cnt_q == TW'(TIMEOUT_CYC - 1));
    assign next_owner = wrap_inc(owner_q, 1);

    // Search downwards so the candidate closest to rr is the last (winning) assignment.
    always_comb begin
        found = 1'b0;
        win   = '0;
        if (locked_q) begin
            found = req_valid[owner_q];
            win   = owner_q;
        end else begin
            for (int k = N - 1; k >= 0; k--) begin
                if (req_valid[wrap_inc(rr_q, k)]) begin
                    found = 1'b1;
                    win   = wrap_inc(rr_q, k);
                end
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        tx_start_d = tx_start_q;
        tx_data_d  = tx_data_q;
        req_ack_d  = '0;
        owner_d    = owner_q;
        locked_d   = locked_q;
        err_d      = 1'b0;
        rr_d       = rr_q;
        cnt_d      = cnt_q + TW'(1);
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (found) begin
                    tx_data_d      = req_data[{win, 3'b000} +: 8];
                    req_ack_d[win] = 1'b1;
                    owner_d        = win;
                    locked_d       = ~req_last[win];
                    tx_start_d     = 1'b1;
                    state_d        = S_START;
                end
            end
            S_START: begin
                if (rise) begin
                    tx_start_d = 1'b0;
                    state_d    = S_DONE;
                end else if (timeout) begin
                    tx_start_d = 1'b0;
                    locked_d   = 1'b0;
                    err_d      = 1'b1;
                    rr_d       = next_owner;
                    state_d    = S_IDLE;
                end
            end
            S_DONE: begin
                if (fall) begin
                    if (!locked_q) rr_d = next_owner;
                    state_d = S_IDLE;
                end else if (timeout) begin
                    locked_d = 1'b0;
                    err_d    = 1'b1;
                    rr_d     = next_owner;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (state_d != state_q) cnt_d = '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
            req_ack_q  <= '0;
            owner_q    <= '0;
            locked_q   <= 1'b0;
            err_q      <= 1'b0;
            rr_q       <= '0;
            ready_q    <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            req_ack_q  <= req_ack_d;
            owner_q    <= owner_d;
            locked_q   <= locked_d;
            err_q      <= err_d;
            rr_q       <= rr_d;
            ready_q    <= ready_d;
            cnt_q      <= cnt_d;
        end
    end

    assign req_ack     = req_ack_q;
    assign tx_start    = tx_start_q;
    assign tx_data     = tx_data_q;
    assign owner       = owner_q;
    assign locked      = locked_q;
    assign busy        = (state_q != S_IDLE);
    assign err_timeout = err_q;
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb/tb_uart_tx_scheduler.sv - self-checking bench for uart_tx_scheduler
module tb_uart_tx_scheduler;
    localparam int N    = 4;
    localparam int TO_A = 1000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]   req_valid, req_last;
    logic [8*N-1:0] req_data;
    logic           tx_ready = 1'b0;

    logic [N-1:0] ack_a, ack_t, ack_sel;
    logic         start_a, start_t, locked_a, locked_t, busy_a, busy_t, err_a, err_t;
    logic [7:0]   data_a, data_t, data_sel;
    logic [1:0]   owner_a, owner_t;
    logic         sel_t = 1'b0;

    uart_tx_scheduler #(.N(N), .TIMEOUT_CYC(TO_A), .TW(10)) dut_a (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ack(ack_a), .tx_start(start_a), .tx_data(data_a), .tx_ready(tx_ready),
        .owner(owner_a), .locked(locked_a), .busy(busy_a), .err_timeout(err_a));

    uart_tx_scheduler #(.N(N), .TIMEOUT_CYC(100), .TW(7)) dut_t (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ack(ack_t), .tx_start(start_t), .tx_data(data_t), .tx_ready(1'b0),
        .owner(owner_t), .locked(locked_t), .busy(busy_t), .err_timeout(err_t));

    assign ack_sel  = sel_t ? ack_t : ack_a;
    assign data_sel = sel_t ? data_t : data_a;

    int tests_run = 0;
    int tests_failed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Requester queues: {last, data}; head advanced on ack, tail by the tests.
    logic [8:0] rmem [N][64];
    int rhead [N] = '{default: 0};
    int rtail [N] = '{default: 0};
    logic [N-1:0] hold = '0;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            req_valid[i]       = !hold[i] && (rhead[i] != rtail[i]);
            req_last[i]        = rmem[i][rhead[i] & 63][8];
            req_data[8*i +: 8] = rmem[i][rhead[i] & 63][7:0];
        end
    end

    task automatic push(input int i, input logic last, input logic [7:0] d);
        rmem[i][rtail[i] & 63] = {last, d};
        rtail[i]++;
    endtask

    int log_req [256];
    logic [7:0] log_data [256];
    int log_n = 0;

    initial forever begin
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (ack_sel[i]) begin
                log_req[log_n & 255]  = i;
                log_data[log_n & 255] = data_sel;
                log_n++;
                rhead[i]++;
            end
        end
    end

    // Transmitter: ready rises 160 clk after start, falls 40 clk later.
    logic xmit_active = 1'b0;
    initial forever begin
        @(posedge clk);
        if (start_a && !tx_ready) begin
            xmit_active = 1'b1;
            repeat (159) @(posedge clk);
            #1 tx_ready = 1'b1;
            repeat (40) @(posedge clk);
            #1 tx_ready = 1'b0;
            xmit_active = 1'b0;
        end
    end

    // Transaction-level model of dut_a: phase 0 idle, 1 byte offered, 2 waiting for ready to drop.
    int m_phase = 0, m_cnt = 0, m_rr = 0, m_owner = 0, w;
    logic m_locked = 0, m_start = 0, m_err = 0, m_rdy = 0, m_rise, m_fall;
    logic [7:0] m_data = '0;
    logic [N-1:0] m_ack = '0;

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_phase = 0; m_cnt = 0; m_rr = 0; m_owner = 0;
            m_locked = 0; m_start = 0; m_err = 0; m_rdy = 0; m_data = '0; m_ack = '0;
        end else begin
            m_rise = tx_ready && !m_rdy;
            m_fall = !tx_ready && m_rdy;
            m_rdy  = tx_ready;
            m_ack  = '0;
            m_err  = 1'b0;
            if (m_phase == 0) begin
                w = -1;
                if (m_locked) begin
                    if (req_valid[m_owner]) w = m_owner;
                end else begin
                    for (int k = N - 1; k >= 0; k--)
                        if (req_valid[(m_rr + k) % N]) w = (m_rr + k) % N;
                end
                if (w >= 0) begin
                    m_data = req_data[8*w +: 8];
                    m_ack[w] = 1'b1;
                    m_owner = w;
                    m_locked = !req_last[w];
                    m_start = 1'b1;
                    m_phase = 1;
                    m_cnt = 0;
                end
            end else if (m_phase == 1 && m_rise) begin
                m_start = 1'b0;
                m_phase = 2;
                m_cnt = 0;
            end else if (m_phase == 2 && m_fall) begin
                if (!m_locked) m_rr = (m_owner + 1) % N;
                m_phase = 0;
            end else begin
                m_cnt++;
                if (m_cnt == TO_A) begin
                    m_start = 1'b0;
                    m_locked = 1'b0;
                    m_err = 1'b1;
                    m_rr = (m_owner + 1) % N;
                    m_phase = 0;
                end
            end
        end
    end

    initial forever begin
        @(negedge clk);
        check("cycle_a", {ack_a, start_a, data_a, owner_a, locked_a, busy_a, err_a},
              {m_ack, m_start, m_data, 2'(m_owner), m_locked, m_phase != 0, m_err});
    end

    task automatic do_reset();
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic wait_log(input int n, input int budget);
        int c = 0;
        while (log_n < n && c < budget) begin
            @(negedge clk);
            c++;
        end
        check("wait_log", 32'(log_n >= n), 1);
    endtask

    task automatic wait_idle();
        int c = 0;
        while ((busy_a || xmit_active || tx_ready) && c < 3000) begin
            @(negedge clk);
            c++;
        end
        check("wait_idle", 32'(busy_a || xmit_active || tx_ready), 0);
    endtask

    task automatic check_log(input string name, input int idx, input int r, input logic [7:0] d);
        check(name, {log_req[idx & 255][7:0], log_data[idx & 255]}, {r[7:0], d});
    endtask

    int base, n;

    initial begin
        repeat (2) @(negedge clk);
        check("reset_a", {ack_a, start_a, data_a, owner_a, locked_a, busy_a, err_a}, 0);
        check("reset_t", {ack_t, start_t, data_t, owner_t, locked_t, busy_t, err_t}, 0);

        // Single byte, then verify rr moved to 3.
        do_reset();
        base = log_n;
        push(2, 1'b1, 8'h55);
        n = 0;
        while (!tx_ready && n < 400) begin @(negedge clk); n++; end
        check("start_before_rise", 32'(start_a), 1);
        @(negedge clk);
        check("start_after_rise", 32'(start_a), 0);
        wait_idle();
        check_log("single_byte", base, 2, 8'h55);
        check("single_owner", 32'(owner_a), 2);
        check("single_locked", 32'(locked_a), 0);
        push(0, 1'b1, 8'h0A);
        push(3, 1'b1, 8'h3A);
        wait_log(base + 3, 1000);
        check_log("rr_after_single_0", base + 1, 3, 8'h3A);
        check_log("rr_after_single_1", base + 2, 0, 8'h0A);
        wait_idle();

        // Round robin over requesters 0, 1, 3.
        do_reset();
        base = log_n;
        push(0, 1'b1, 8'h01); push(0, 1'b1, 8'h02);
        push(1, 1'b1, 8'h11); push(1, 1'b1, 8'h12);
        push(3, 1'b1, 8'h31); push(3, 1'b1, 8'h32);
        wait_log(base + 6, 2000);
        check_log("rr_0", base + 0, 0, 8'h01);
        check_log("rr_1", base + 1, 1, 8'h11);
        check_log("rr_2", base + 2, 3, 8'h31);
        check_log("rr_3", base + 3, 0, 8'h02);
        check_log("rr_4", base + 4, 1, 8'h12);
        check_log("rr_5", base + 5, 3, 8'h32);
        wait_idle();

        // Packet lock: requester 1 keeps the grant while requester 0 waits.
        do_reset();
        base = log_n;
        hold[0] = 1'b1;
        push(0, 1'b1, 8'h0B);
        push(1, 1'b0, 8'hA0); push(1, 1'b0, 8'hA1); push(1, 1'b1, 8'hA2);
        wait_log(base + 1, 50);
        check("lock_set", 32'(locked_a), 1);
        hold[0] = 1'b0;
        wait_log(base + 2, 1000);
        check("lock_held", 32'(locked_a), 1);
        wait_log(base + 3, 1000);
        check("lock_clear", 32'(locked_a), 0);
        wait_log(base + 4, 1000);
        check_log("lock_0", base + 0, 1, 8'hA0);
        check_log("lock_1", base + 1, 1, 8'hA1);
        check_log("lock_2", base + 2, 1, 8'hA2);
        check_log("lock_3", base + 3, 0, 8'h0B);
        wait_idle();

        // Locked stall: requester 2 waits until requester 1 finishes its packet.
        do_reset();
        base = log_n;
        push(1, 1'b0, 8'h10);
        wait_log(base + 1, 50);
        push(2, 1'b1, 8'h20);
        repeat (700) @(negedge clk);
        check("stall_count", 32'(log_n - base), 1);
        check("stall_locked", 32'(locked_a), 1);
        check("stall_busy", 32'(busy_a), 0);
        push(1, 1'b1, 8'h11);
        wait_log(base + 3, 1000);
        check_log("stall_0", base + 0, 1, 8'h10);
        check_log("stall_1", base + 1, 1, 8'h11);
        check_log("stall_2", base + 2, 2, 8'h20);
        wait_idle();

        // Timeout on dut_t (TIMEOUT_CYC=100, ready never rises).
        sel_t = 1'b1;
        do_reset();
        base = log_n;
        push(2, 1'b0, 8'h77); push(2, 1'b1, 8'h78);
        push(3, 1'b1, 8'h88);
        n = 0;
        while (!start_t && n < 20) begin @(negedge clk); n++; end
        n = 0;
        while (start_t && n < 300) begin n++; @(negedge clk); end
        check("to_width", n, 100);
        check("to_err", 32'(err_t), 1);
        check("to_locked", 32'(locked_t), 0);
        @(negedge clk);
        check("to_err_pulse", 32'(err_t), 0);
        wait_log(base + 3, 500);
        check_log("to_0", base + 0, 2, 8'h77);
        check_log("to_1", base + 1, 3, 8'h88);
        check_log("to_2", base + 2, 2, 8'h78);
        sel_t = 1'b0;
        wait_idle();

        // Reset mid-transfer, then requester 0 has priority again.
        do_reset();
        base = log_n;
        push(3, 1'b1, 8'h33);
        n = 0;
        while (!start_a && n < 20) begin @(negedge clk); n++; end
        repeat (3) @(negedge clk);
        check("mid_busy", 32'(busy_a), 1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_start", 32'(start_a), 0);
        check("mid_rst_busy", 32'(busy_a), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        push(3, 1'b1, 8'h34);
        push(0, 1'b1, 8'h0A);
        wait_log(base + 3, 2000);
        check_log("mid_0", base + 1, 0, 8'h0A);
        check_log("mid_1", base + 2, 3, 8'h34);
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
